uart_receiver: RTL and testbench

- Serial-to-parallel UART receive path. The counterpart of uart_transmitter on the same link: 8N1 framing, LSB first, idle-high line.
- Samples the asynchronous rx_serial pin at mid-bit using a divide counter on PCLK.
- Presents each received byte on rx_data with a one-cycle rx_done strobe, for the APB register block to capture.

---
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 tb/tb_uart_receiver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: two-flop synchronised line, mid-bit sampling from a PCLK divide counter.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and the rx_parity_err output.
module uart_receiver #(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       clk_cnt, cnt_next;
  logic [IDX_W-1:0]       bit_idx, idx_next;
  logic [DATA_BITS-1:0]   shift, shift_next;
  logic [DATA_BITS-1:0]   data_next;
  logic                   done_next;
  logic                   ferr_next;
  logic                   rx_meta, rx_s, rx_s_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bit, par_next;
  logic                   perr_next;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = clk_cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    data_next  = rx_data;
    done_next  = 1'b0;
    ferr_next  = rx_frame_err;
`ifdef UART_RX_PARITY_EN
    par_next   = parity_bit;
    perr_next  = rx_parity_err;
`endif
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        // Edge-triggered start: a line held low (break) never re-arms the receiver.
        if (rx_s_d && !rx_s) state_next = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) begin
            idx_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_next = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_next   = '0;
          par_next   = rx_s;
          state_next = STOP;
        end else begin
          cnt_next = clk_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (clk_cnt == CNT_FULL) begin
          cnt_next   = '0;
          data_next  = shift;
          ferr_next  = ~rx_s;
          done_next  = 1'b1;
          state_next = IDLE;
`ifdef UART_RX_PARITY_EN
          perr_next  = (^shift) ^ parity_bit;
`endif
        end else begin
          cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_s_d       <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      clk_cnt      <= cnt_next;
      bit_idx      <= idx_next;
      shift        <= shift_next;
      rx_data      <= data_next;
      rx_done      <= done_next;
      rx_frame_err <= ferr_next;
      rx_meta      <= rx_serial;
      rx_s         <= rx_meta;
      rx_s_d       <= rx_s;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= par_next;
      rx_parity_err <= perr_next;
`endif
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, glitch/break/reset sequences,
// then random frames compared against a frame-level reference model.
module tb_uart_receiver;

  localparam int BAUD_RATE = 9600;
  localparam int CLK_FREQ  = 153_600;
  localparam int DATA_BITS = 8;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 2;
`else
  localparam int FRAME_BITS = DATA_BITS + 1;
`endif
  localparam int EXP_LAT = 2 + HALF + FRAME_BITS * CPB + 1;

  logic                 PCLK;
  logic                 PRESET;
  logic                 rx_serial;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_busy;
  logic                 rx_done;
  logic                 rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 rx_parity_err;
`endif

  uart_receiver #(
    .BAUD_RATE(BAUD_RATE),
    .CLK_FREQ (CLK_FREQ),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_busy     (rx_busy),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_bad;
    int         tail_low;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         cyc;
  } rec_t;

  rec_t       done_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         hold_viol = 0;
  logic       rst_at_edge = 1'b1;
  logic [7:0] last_data = 8'h00;
  logic       busy_bad;

  always @(posedge PCLK) begin
    cyc++;
    rst_at_edge = PRESET;
  end

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge PCLK) begin
    rec_t r;
    if (rx_done === 1'b1) begin
      r.data = rx_data;
      r.ferr = rx_frame_err;
`ifdef UART_RX_PARITY_EN
      r.perr = rx_parity_err;
`else
      r.perr = 1'b0;
`endif
      r.cyc = cyc;
      done_q.push_back(r);
    end
    if (rx_done !== 1'b1 && !rst_at_edge && rx_data !== last_data) hold_viol++;
    last_data = rx_data;
  end

  initial begin
    repeat (50000) @(posedge PCLK);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, required < 50000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input logic chk_busy);
    rx_serial = b;
    for (int c = 0; c < CPB; c++) begin
      @(negedge PCLK);
      if (c == 6 && chk_busy && rx_busy !== 1'b1) busy_bad = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                            input int tail_low, input int gap, output int start);
    busy_bad = 1'b0;
    start    = cyc;
    drive_bit(1'b0, 1'b1);
    for (int k = 0; k < DATA_BITS; k++) drive_bit(d[k], 1'b1);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_bad, 1'b1);
`endif
    drive_bit(stop, 1'b0);
    check("busy_in_frame", {31'd0, busy_bad}, 32'd0);
    for (int k = 0; k < tail_low; k++) drive_bit(1'b0, 1'b0);
    for (int k = 0; k < gap; k++) drive_bit(1'b1, 1'b0);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe,
                              input logic pe, input int start);
    rec_t r;
    int   waited = 0;
    while (done_q.size() == 0 && waited < 4 * CPB) begin
      @(negedge PCLK);
      waited++;
    end
    check({tag, "_done"}, {31'd0, done_q.size() != 0}, 32'd1);
    if (done_q.size() != 0) begin
      r = done_q.pop_front();
      check({tag, "_data"}, {24'd0, r.data}, {24'd0, d});
      check({tag, "_ferr"}, {31'd0, r.ferr}, {31'd0, fe});
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, {31'd0, r.perr}, {31'd0, pe});
`endif
      check({tag, "_latency_ok"},
            {31'd0, (r.cyc - start >= EXP_LAT - 1) && (r.cyc - start <= EXP_LAT + 1)}, 32'd1);
    end
  endtask

  initial begin
    vec_t       vecs[9];
    int         start;
    logic       busy_seen;
    logic [7:0] d;
    logic       stop, pb, exp_perr, par_sent;
    int         gap, tail;

    vecs[0] = '{8'h55, 1'b1, 1'b0, 0, 0, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h99, 1'b1, 1'b0, 0, 2, 8'h99, 1'b0, 1'b0};
    vecs[2] = '{8'hA3, 1'b0, 1'b0, 3, 2, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b1, 1'b0, 0, 2, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 0, 1, 8'h07, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 0, 2, 8'h07, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 0, 1, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 0, 1, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h5A, 1'b0, 1'b0, 0, 2, 8'h5A, 1'b1, 1'b0};

    rx_serial = 1'b1;
    PRESET    = 1'b1;
    repeat (4) @(negedge PCLK);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_done", {31'd0, rx_done}, 32'd0);
    check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", {31'd0, rx_parity_err}, 32'd0);
`endif
    PRESET = 1'b0;
    repeat (2 * CPB) @(negedge PCLK);
    check("idle_after_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("idle_after_rst_nodone", done_q.size(), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_bad, vecs[i].tail_low, vecs[i].gap, start);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr,
                   vecs[i].exp_perr, start);
      if (vecs[i].gap > 0) check($sformatf("vec%0d_idle_busy", i), {31'd0, rx_busy}, 32'd0);
    end

    // Short glitch: a false start must not strobe or disturb the held outputs.
    busy_seen = 1'b0;
    rx_serial = 1'b0;
    repeat (3) @(negedge PCLK);
    rx_serial = 1'b1;
    for (int c = 0; c < HALF + 6; c++) begin
      if (rx_busy === 1'b1) busy_seen = 1'b1;
      @(negedge PCLK);
    end
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_back_idle", {31'd0, rx_busy}, 32'd0);
    repeat (2 * CPB) @(negedge PCLK);
    check("glitch_nodone", done_q.size(), 32'd0);
    check("glitch_data_held", {24'd0, rx_data}, 32'h5A);
    check("glitch_ferr_held", {31'd0, rx_frame_err}, 32'd1);

    // Reset pulse in the middle of data bit 4 discards the frame.
    d = 8'hE7;
    busy_bad = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(d[k], 1'b0);
    rx_serial = d[4];
    repeat (HALF) @(negedge PCLK);
    PRESET    = 1'b1;
    rx_serial = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_done", {31'd0, rx_done}, 32'd0);
    check("midrst_ferr", {31'd0, rx_frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check("midrst_perr", {31'd0, rx_parity_err}, 32'd0);
`endif
    repeat (12 * CPB) @(negedge PCLK);
    check("midrst_nodone", done_q.size(), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 1, start);
    expect_frame("after_rst", 8'h3C, 1'b0, 1'b0, start);

    // Random frames against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pb   = ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(0, 2);
      tail = stop ? 0 : $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      par_sent = (^d) ^ pb;
      exp_perr = (^d) ^ par_sent;
      send_frame(d, stop, pb, tail, gap, start);
      expect_frame($sformatf("rnd%0d", i), d, ~stop, exp_perr, start);
    end

    repeat (2 * CPB) @(negedge PCLK);
    check("no_spurious_done", done_q.size(), 32'd0);
    check("rx_data_hold_between_frames", hold_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
